// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone user-port mux.
// The status register layout here is only used when WB_MUX_STATUS_EN is defined.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_C0DE;

    localparam int STAT_STICKY_BIT = 0;
    localparam int STAT_PORT_LSB   = 4;
    localparam int STAT_CNT_LSB    = 16;

    function automatic logic [31:0] status_word(input logic [15:0] to_cnt,
                                                input logic [3:0]  last_port,
                                                input logic        sticky);
        logic [31:0] w;
        w                            = '0;
        w[STAT_CNT_LSB +: 16]        = to_cnt;
        w[STAT_PORT_LSB +: 4]        = last_port;
        w[STAT_STICKY_BIT]           = sticky;
        return w;
    endfunction

endpackage

// File: rtl/wb_user_port_mux_if.sv
// Management-side Wishbone slave bus of the user-port mux.
interface wb_user_port_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_mux_timeout.sv
// Bus-error timeout counter: cleared on load, counts while enabled, sticks at TIMEOUT.
module wb_mux_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_user_port_mux.sv
// Wishbone fabric from the mgmt user-area port to NUM_PORTS sub-projects, with bus-error timeout.
// Define WB_MUX_STATUS_EN to map a status register at the top port index.
module wb_user_port_mux
    import wb_mux_pkg::*;
#(
    parameter int          NUM_PORTS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SPAN_LOG2 = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    wb_user_port_mux_if.slave         wbs,
    input  logic [NUM_PORTS-1:0]      port_en_i,
    output logic [NUM_PORTS-1:0]      m_cyc_o,
    output logic [NUM_PORTS-1:0]      m_stb_o,
    output logic                      m_we_o,
    output logic [3:0]                m_sel_o,
    output logic [31:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic [NUM_PORTS-1:0]      m_ack_i,
    input  logic [32*NUM_PORTS-1:0]   m_dat_i
);

    localparam int IDX_W  = $clog2(NUM_PORTS + 1);
    localparam int HI_LSB = SPAN_LOG2 + IDX_W;
    localparam int NSLOT  = 2 ** IDX_W;

    state_e           state;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] idx_q;
    logic [NSLOT-1:0] en_pad;
    logic [NSLOT-1:0] ack_pad;
    logic             hit;
    logic             port_ok;
    logic             stat_sel;
    logic             accept;
    logic             sel_ack;
    logic             expired;
    logic             ack_q;
    logic [31:0]      rd_data_q;
    logic [31:0]      sel_dat;
    logic [31:0]      status_rd;

    // Zero-padded enable/ack vectors make indices >= NUM_PORTS decode as not present.
    assign en_pad  = NSLOT'(port_en_i);
    assign ack_pad = NSLOT'(m_ack_i);

    assign req_idx = wbs.wbs_adr_i[SPAN_LOG2 +: IDX_W];
    assign hit     = (wbs.wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
    assign port_ok = hit && en_pad[req_idx];
    assign accept  = (state == ST_IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i;
    assign sel_ack = ack_pad[idx_q];

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (idx_q == IDX_W'(k)) sel_dat = m_dat_i[32*k +: 32];
        end
    end

    assign wbs.wbs_ack_o = ack_q & wbs.wbs_cyc_i;
    assign wbs.wbs_dat_o = rd_data_q;

    wb_mux_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .load    (accept),
        .en      (state == ST_REQ),
        .expired (expired)
    );

`ifdef WB_MUX_STATUS_EN
    logic [15:0] to_cnt;
    logic [3:0]  last_to_port;
    logic        sticky_err;
    logic        timeout_evt;
    logic        miss_evt;

    assign stat_sel    = hit && (req_idx == {IDX_W{1'b1}});
    assign status_rd   = status_word(to_cnt, last_to_port, sticky_err);
    assign timeout_evt = (state == ST_REQ) && wbs.wbs_cyc_i && !sel_ack && expired;
    assign miss_evt    = accept && !port_ok && !stat_sel;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_cnt       <= '0;
            last_to_port <= '0;
            sticky_err   <= 1'b0;
        end else if (accept && !port_ok && stat_sel && wbs.wbs_we_i) begin
            to_cnt       <= '0;
            last_to_port <= '0;
            sticky_err   <= 1'b0;
        end else begin
            if (timeout_evt) begin
                if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
                last_to_port <= 4'(idx_q);
                sticky_err   <= 1'b1;
            end
            if (miss_evt) sticky_err <= 1'b1;
        end
    end
`else
    assign stat_sel  = 1'b0;
    assign status_rd = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (accept) begin
                        if (port_ok) begin
                            idx_q   <= req_idx;
                            m_we_o  <= wbs.wbs_we_i;
                            m_sel_o <= wbs.wbs_sel_i;
                            m_adr_o <= 32'(wbs.wbs_adr_i[SPAN_LOG2-1:0]);
                            m_dat_o <= wbs.wbs_dat_i;
                            m_cyc_o <= NUM_PORTS'(1) << req_idx;
                            m_stb_o <= NUM_PORTS'(1) << req_idx;
                            state   <= ST_REQ;
                        end else if (stat_sel) begin
                            rd_data_q <= wbs.wbs_we_i ? 32'h0 : status_rd;
                            ack_q     <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            rd_data_q <= ERR_DATA;
                            ack_q     <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    // Master abandoning the cycle takes priority: no ack is owed.
                    if (!wbs.wbs_cyc_i) begin
                        m_cyc_o <= '0;
                        m_stb_o <= '0;
                        state   <= ST_IDLE;
                    end else if (sel_ack) begin
                        rd_data_q <= m_we_o ? 32'h0 : sel_dat;
                        m_cyc_o   <= '0;
                        m_stb_o   <= '0;
                        ack_q     <= 1'b1;
                        state     <= ST_RESP;
                    end else if (expired) begin
                        rd_data_q <= ERR_DATA;
                        m_cyc_o   <= '0;
                        m_stb_o   <= '0;
                        ack_q     <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
